// File: rtl/hamming_serial_tx.sv
// ---------------------------------------------------------------------------
// hamming_serial_tx
// Serial transmitter for the Hamming-protected shift-register link.
// A parallel word is accepted through a valid/ready handshake and split into
// 4-bit nibbles. Each nibble becomes a 7-bit codeword sent in the order
// d0,d1,d2,d3,p1,p2,p3. The codewords go out LSB-first, nibble 0 first,
// inside a start (0) / stop (1) frame. Each serial bit is held BIT_CYCLES
// clocks. One code bit of a frame can optionally be inverted so the
// receiver's correction path can be exercised.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   in_valid   : in_data is offered for transmission
//   in_data    : word to transmit (WIDTH bits, multiple of 4)
//   inj_en     : sampled at accept, flip one code bit of this frame
//   inj_pos    : index of the code bit to flip (0 = first code bit sent)
//   in_ready   : a word can be accepted this cycle (IDLE only)
//   tx_out     : serial line, idles high
//   busy       : frame in progress (START, DATA, STOP)
//   frame_done : one-cycle pulse on the last cycle of the stop bit
// ---------------------------------------------------------------------------
module hamming_serial_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  localparam int NIB = WIDTH / 4,
  localparam int SW  = 7 * NIB,
  localparam int IPW = $clog2(SW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             inj_en,
  input  logic [IPW-1:0]   inj_pos,
  output logic             in_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (SW > 1) ? $clog2(SW) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SW - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Codeword packed so that bit 0 is the first bit on the wire.
  function automatic logic [6:0] enc_nibble(input logic [3:0] d);
    logic p1;
    logic p2;
    logic p3;
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[0] ^ d[1] ^ d[3];
    p3 = d[0] ^ d[1] ^ d[2];
    return {p3, p2, p1, d[3], d[2], d[1], d[0]};
  endfunction

  state_t           r_state;
  logic [CW-1:0]    r_cyc;
  logic [BW-1:0]    r_bit;
  logic [SW-1:0]    r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cyc_nxt;
  logic [BW-1:0]    w_bit_nxt;
  logic [SW-1:0]    w_shift_nxt;
  logic [SW-1:0]    w_code;
  logic [SW-1:0]    w_flip;
  logic             w_accept;
  logic             w_tx_nxt;

  assign w_accept = in_valid && r_ready;

  // Encode every nibble and build the injection mask for the captured frame.
  // An out-of-range inj_pos matches no stream index, so nothing is flipped.
  always_comb begin
    w_code = '0;
    w_flip = '0;
    for (int n = 0; n < NIB; n++) begin
      w_code[7*n +: 7] = enc_nibble(in_data[4*n +: 4]);
    end
    for (int i = 0; i < SW; i++) begin
      w_flip[i] = inj_en && (inj_pos == IPW'(i));
    end
  end

  // Next-state, counter and shift-register logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        w_cyc_nxt = '0;
        w_bit_nxt = '0;
        if (w_accept) begin
          w_state_nxt = ST_START;
          w_shift_nxt = w_code ^ w_flip;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (r_cyc == CYC_LAST) begin
          w_state_nxt = ST_DATA;
          w_cyc_nxt   = '0;
          w_bit_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + CW'(1);
        end
      end
      ST_DATA: begin
        if (r_cyc == CYC_LAST) begin
          w_cyc_nxt = '0;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = ST_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt   = r_bit + BW'(1);
            // The next bit to send is always at the bottom of the register.
            w_shift_nxt = r_shift >> 1;
          end
        end else begin
          w_cyc_nxt = r_cyc + CW'(1);
        end
      end
      ST_STOP: begin
        if (r_cyc == CYC_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cyc_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Line level for the state being entered, so the registered tx_out lines
  // up with the state register (start bit appears right after accept).
  always_comb begin
    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_STOP) && (w_cyc_nxt == CYC_LAST);
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  assign tx_out     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign in_ready   = r_ready;

endmodule

// File: doc/hamming_serial_tx.md
Name: hamming_serial_tx

Overview:
Serial transmitter for the Hamming-protected shift-register link. It accepts a parallel word through a valid/ready handshake and splits it into 4-bit nibbles. Each nibble is encoded into a 7-bit codeword (4 data bits, 3 parity bits) and the codewords are shifted out LSB-first inside a start/stop frame. It feeds the serial_in of the receiving correcting register and has an optional single-bit error-injection path for exercising the receiver's correction logic.

Parameters:
WIDTH, 8, data word width; must be a multiple of 4 (NIB = WIDTH/4 nibbles).
BIT_CYCLES, 1, clock cycles each serial bit is held on tx_out; must be >= 1.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  in_data is offered for transmission.
in_data  input  WIDTH  word to transmit.
inj_en  input  1  sampled at accept: flip one code bit of this frame.
inj_pos  input  $clog2(7*NIB)  index of the code bit to flip (0 = first code bit sent).
in_ready  output  1  block can accept a word this cycle.
tx_out  output  1  serial line; idles high.
busy  output  1  frame in progress.
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async, rst=0): state IDLE, tx_out=1, in_ready=0 while rst is low, busy=0, frame_done=0, all counters and shift register cleared. Reset mid-frame aborts the frame immediately with no stop bit and does not resume.
- Per-nibble encoding (nibble n = in_data[4n+3:4n], bits d0..d3):
  - p1 = d0^d2^d3, p2 = d0^d1^d3, p3 = d0^d1^d2.
  - Codeword transmit order: d0, d1, d2, d3, p1, p2, p3.
  - Nibble 0 is sent first, then nibble 1, and so on.
- Code stream is 7*NIB bits and is built at accept into an internal shift register. If inj_en=1 and inj_pos < 7*NIB, stream bit inj_pos is inverted; if inj_pos is out of range, injection is ignored.
- Handshake: in_ready=1 only in IDLE (and rst=1). A word is accepted on a rising clk edge with in_valid && in_ready. in_data, inj_en and inj_pos are captured only at accept; later changes have no effect. in_valid while not ready is ignored; there is no queueing.
- FSM:
  - IDLE: tx_out=1, busy=0. On accept go to START.
  - START: tx_out=0 for BIT_CYCLES cycles, then DATA.
  - DATA: tx_out = current stream bit; each bit is held BIT_CYCLES cycles; 7*NIB bits are sent in order; then STOP.
  - STOP: tx_out=1 for BIT_CYCLES cycles. frame_done=1 on the final STOP cycle. Then IDLE.
- Latency: the start bit appears on tx_out in the cycle after the accept edge. Frame length is (2 + 7*NIB)*BIT_CYCLES cycles, followed by at least 1 IDLE cycle (the next accept happens in IDLE) before the next start bit.
- busy=1 in START, DATA and STOP.
- Bit counter counts 0..7*NIB-1 and cycle counter counts 0..BIT_CYCLES-1. Both reset to 0 on every bit and state transition and never wrap inside a state.
- All outputs are registered (tx_out driven from a flop) so the line is glitch-free.

Test Plan:
- Reset, then rst=1 with in_valid=0 -> tx_out=1, in_ready=1, busy=0 indefinitely.
- BIT_CYCLES=1, in_data=0xA5, inj_en=0 -> tx_out after accept: 0, 1010010, 0101101, 1. frame_done pulses on the stop cycle; in_ready returns to 1 in the next cycle.
- in_data=0x00 then 0xFF back-to-back with in_valid held high -> frame 1 has 14 zero code bits, frame 2 has 14 one code bits. Exactly 1 IDLE cycle (tx_out=1) between the stop bit and the next start bit; no word is lost or repeated.
- in_data=0xA5, inj_en=1, inj_pos=2 -> third code bit sent as 0 instead of 1, all other bits unchanged. With inj_pos=15 -> frame identical to the uninjected one.
- BIT_CYCLES=4, in_data=0x3C -> every bit held exactly 4 cycles; total frame 64 cycles; frame_done high for exactly 1 cycle.
- Assert rst=0 during DATA bit 5 -> tx_out=1 and busy=0 immediately. After release, in_ready=1 and the next accepted word is sent as a complete, correct frame.
